rv32i_regfile_fwd: RTL and testbench
====================================

Name: rv32i_regfile_fwd

Overview:
Integer register file plus operand-forwarding read stage for the RV32I pipeline. It accepts the writeback triple (enable, register, data) from the writeback stage and the forwarded triples from the EX, MEM and WB stages. It resolves rs1/rs2 operands for the instruction in decode and registers them into the ID/EX boundary. Its job is to consume what the writeback stage produces, so that dependent instructions see correct values without software NOPs.

Parameters:
XLEN, 32, data width of registers and operands
NREGS, 32, architectural register count; addresses are 5 bits; x0 is hardwired to zero
RESET_CLEAR, 1, 1 = all registers cleared on reset; 0 = register contents untouched by reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  reset, synchronous, active-high
rs1_addr  in  5  decode-stage source register 1
rs2_addr  in  5  decode-stage source register 2
stall_in  in  1  hold ID/EX outputs
flush_in  in  1  replace ID/EX outputs with bubble
wb_en  in  1  writeback enable
wb_reg  in  5  writeback register
wb_data  in  XLEN  writeback data
df_ex_enable / df_ex_reg / df_ex_data  in  1/5/XLEN  forwarded result, EX stage
df_mem_enable / df_mem_reg / df_mem_data  in  1/5/XLEN  forwarded result, MEM stage
df_wb_enable / df_wb_reg / df_wb_data  in  1/5/XLEN  forwarded result, WB stage
ex_is_load  in  1  instruction in EX is a load (used only with the optional feature)
rs1_data_out  out  XLEN  registered operand 1
rs2_data_out  out  XLEN  registered operand 2
rs1_addr_out  out  5  registered rs1 address
rs2_addr_out  out  5  registered rs2 address
stall_out  out  1  load-use stall request (0 when the optional feature is absent)

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - If RESET_CLEAR=1, regs[1..31] go to 0.
  - Writes are suppressed during any reset cycle.
- Write:
  - On a clock edge with wb_en=1, wb_reg!=0 and reset=0: regs[wb_reg] <= wb_data.
  - Writes to x0 are ignored.
  - Writes proceed regardless of stall_in and flush_in.
- Operand select (combinational, per source port; the first match wins):
  - addr==0 -> 0
  - df_ex_enable && df_ex_reg==addr -> df_ex_data
  - df_mem_enable && df_mem_reg==addr -> df_mem_data
  - df_wb_enable && df_wb_reg==addr -> df_wb_data
  - wb_en && wb_reg==addr -> wb_data (write-through for a same-cycle write)
  - otherwise regs[addr]
- Forwarding never targets x0, even if a stage presents reg 0 with its enable high.
- Latency: 1 cycle. Addresses presented in cycle N appear on *_out after edge N+1.
- Output register update priority: reset > flush_in > stall_in > load.
  - flush_in: all four outputs go to 0 (bubble).
  - stall_in: outputs hold their current values.
- Simultaneous stall_in and flush_in: flush wins.
- Both ports are independent. rs1_addr==rs2_addr yields identical data on both ports.

Optional Feature:
RF_LOAD_USE_STALL_EN
- Defined:
  - stall_out = ex_is_load && df_ex_enable && df_ex_reg!=0 && (df_ex_reg==rs1_addr || df_ex_reg==rs2_addr). This is combinational.
  - While stall_out=1, the ID/EX outputs load a bubble (as flush) in place of the forwarded EX value.
  - Under stall_in, the outputs hold as normal.
- Undefined:
  - stall_out is tied to 0 and ex_is_load is ignored.
  - Load-use hazards are the responsibility of the decode-stage hazard unit.

Decomposition:
- Package rv32i_pkg holds:
  - XLEN
  - REG_ADDR_W=5
  - REG_ZERO=5'd0
  - typedef fwd_t {logic en; logic [4:0] reg; logic [XLEN-1:0] data;} for the df_* triples
- One sub-module, rv32i_fwd_mux: the priority selector for one source port. It is instantiated twice.
- The register array and the ID/EX output register stay in the top module.

Test Plan:
- Reset with RESET_CLEAR=1, then read x1..x31 with no forwarding active -> all outputs 0; stall_out 0.
- Write x5=0xDEADBEEF via wb_en. The next cycle rs1=5 with no df active -> rs1_data_out=0xDEADBEEF one cycle later.
- df_ex {1,7,0x11}, df_mem {1,7,0x22}, df_wb {1,7,0x33}, regs[7]=0x44, rs1=rs2=7 -> both outputs 0x11. Drop the EX entry -> 0x22. Drop MEM -> 0x33. Drop all -> 0x44.
- wb_en with x0=0xFFFFFFFF and df_ex {1,0,0xAAAA5555}, rs1=0 -> rs1_data_out=0, and x0 reads 0 afterwards.
- With outputs =0x12345678, assert stall_in for 3 cycles while the inputs change -> the outputs hold. Then assert stall_in and flush_in together -> the outputs go to 0. Writeback still lands during the stall.
- With RF_LOAD_USE_STALL_EN: ex_is_load=1, df_ex {1,3,x}, rs2=3 -> stall_out=1 the same cycle and a bubble at the next edge. With rs2=4 -> stall_out=0.

Source files
------------

// File: rtl/rv32i_regfile_fwd_pkg.sv
// rv32i_pkg: shared widths, forwarding triple type and hit helper for the regfile slice
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // reg is a keyword, so the register field is called addr
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } fwd_t;

    function automatic logic fwd_hit(input fwd_t f, input logic [REG_ADDR_W-1:0] a);
        return f.en && f.addr == a;
    endfunction

endpackage

// File: rtl/rv32i_fwd_mux.sv
// rv32i_fwd_mux: priority operand selector for one source port (x0, EX, MEM, WB, write-through, regfile)
module rv32i_fwd_mux
    import rv32i_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       rf_data,
    input  fwd_t                  ex,
    input  fwd_t                  mem,
    input  fwd_t                  wb,
    input  fwd_t                  wr,
    output logic [XLEN-1:0]       data
);

    // youngest producer wins; x0 is checked first so no stage can forward into it
    always_comb begin
        data = addr == REG_ZERO  ? '0       :
               fwd_hit(ex, addr)  ? ex.data  :
               fwd_hit(mem, addr) ? mem.data :
               fwd_hit(wb, addr)  ? wb.data  :
               fwd_hit(wr, addr)  ? wr.data  : rf_data;
    end

endmodule

// File: rtl/rv32i_regfile_fwd.sv
// rv32i_regfile_fwd: RV32I register file with operand forwarding and ID/EX output register
// Optional load-use stall request enabled by defining RF_LOAD_USE_STALL_EN.
module rv32i_regfile_fwd #(
    parameter int XLEN        = rv32i_pkg::XLEN,
    parameter int NREGS       = 32,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [XLEN-1:0] wb_data,
    input  logic            df_ex_enable,
    input  logic [4:0]      df_ex_reg,
    input  logic [XLEN-1:0] df_ex_data,
    input  logic            df_mem_enable,
    input  logic [4:0]      df_mem_reg,
    input  logic [XLEN-1:0] df_mem_data,
    input  logic            df_wb_enable,
    input  logic [4:0]      df_wb_reg,
    input  logic [XLEN-1:0] df_wb_data,
    input  logic            ex_is_load,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [4:0]      rs1_addr_out,
    output logic [4:0]      rs2_addr_out,
    output logic            stall_out
);

    import rv32i_pkg::*;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0] rs1_sel, rs2_sel;
    logic            load_use, bubble;
    fwd_t            f_ex, f_mem, f_wb, f_wr;

    assign f_ex  = '{en: df_ex_enable,  addr: df_ex_reg,  data: df_ex_data};
    assign f_mem = '{en: df_mem_enable, addr: df_mem_reg, data: df_mem_data};
    assign f_wb  = '{en: df_wb_enable,  addr: df_wb_reg,  data: df_wb_data};
    assign f_wr  = '{en: wb_en,         addr: wb_reg,     data: wb_data};

`ifdef RF_LOAD_USE_STALL_EN
    assign load_use = ex_is_load && df_ex_enable && df_ex_reg != REG_ZERO &&
                      (df_ex_reg == rs1_addr || df_ex_reg == rs2_addr);
`else
    logic unused_ex_is_load;
    assign unused_ex_is_load = ex_is_load;
    assign load_use = 1'b0;
`endif
    assign stall_out = load_use;

    rv32i_fwd_mux u_rs1_mux (
        .addr(rs1_addr), .rf_data(regs_q[rs1_addr]),
        .ex(f_ex), .mem(f_mem), .wb(f_wb), .wr(f_wr), .data(rs1_sel)
    );

    rv32i_fwd_mux u_rs2_mux (
        .addr(rs2_addr), .rf_data(regs_q[rs2_addr]),
        .ex(f_ex), .mem(f_mem), .wb(f_wb), .wr(f_wr), .data(rs2_sel)
    );

    // regfile next state: reset optionally clears, otherwise writeback lands regardless of stall/flush
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            if (RESET_CLEAR)
                for (int i = 0; i < NREGS; i++) regs_d[i] = '0;
        end else if (wb_en && wb_reg != REG_ZERO) begin
            regs_d[wb_reg] = wb_data;
        end
        regs_d[0] = '0;
    end

    // regfile storage
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // ID/EX next state: reset/flush bubble, then stall hold, then load-use bubble, then load
    always_comb begin
        bubble     = reset || flush_in || (!stall_in && load_use);
        rs1_data_d = bubble ? '0   : stall_in ? rs1_data_q : rs1_sel;
        rs2_data_d = bubble ? '0   : stall_in ? rs2_data_q : rs2_sel;
        rs1_addr_d = bubble ? 5'd0 : stall_in ? rs1_addr_q : rs1_addr;
        rs2_addr_d = bubble ? 5'd0 : stall_in ? rs2_addr_q : rs2_addr;
    end

    // ID/EX boundary register
    always_ff @(posedge clk) begin
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
        rs1_addr_q <= rs1_addr_d;
        rs2_addr_q <= rs2_addr_d;
    end

    assign rs1_data_out = rs1_data_q;
    assign rs2_data_out = rs2_data_q;
    assign rs1_addr_out = rs1_addr_q;
    assign rs2_addr_out = rs2_addr_q;

endmodule

// File: tb/tb_rv32i_regfile_fwd.sv
// tb_rv32i_regfile_fwd: scoreboard bench with directed and random stimulus against a reference model
module tb_rv32i_regfile_fwd;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, wb_en, ex_is_load;
    logic [4:0]  rs1_addr, rs2_addr, wb_reg, df_ex_reg, df_mem_reg, df_wb_reg;
    logic [31:0] wb_data, df_ex_data, df_mem_data, df_wb_data;
    logic        df_ex_enable, df_mem_enable, df_wb_enable;
    logic [31:0] rs1_data_out, rs2_data_out;
    logic [4:0]  rs1_addr_out, rs2_addr_out;
    logic        stall_out;

    always #5 clk = ~clk;

    rv32i_regfile_fwd dut (
        .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .stall_in(stall_in), .flush_in(flush_in),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .df_ex_enable(df_ex_enable), .df_ex_reg(df_ex_reg), .df_ex_data(df_ex_data),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data),
        .df_wb_enable(df_wb_enable), .df_wb_reg(df_wb_reg), .df_wb_data(df_wb_data),
        .ex_is_load(ex_is_load),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
        .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .stall_out(stall_out)
    );

    typedef struct {
        logic [31:0] d1, d2;
        logic [4:0]  a1, a2;
        logic        so;
    } exp_t;

    exp_t        sb[$];
    exp_t        mout;
    logic [31:0] mregs [32];
    int          passed = 0;
    int          total  = 0;

    // architectural operand value: sources scanned youngest first, x0 always zero
    function automatic logic [31:0] operand(input logic [4:0] a);
        logic        en [4];
        logic [4:0]  r  [4];
        logic [31:0] d  [4];
        en = '{df_ex_enable, df_mem_enable, df_wb_enable, wb_en};
        r  = '{df_ex_reg, df_mem_reg, df_wb_reg, wb_reg};
        d  = '{df_ex_data, df_mem_data, df_wb_data, wb_data};
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < 4; i++)
            if (en[i] && r[i] == a) return d[i];
        return mregs[a];
    endfunction

    function automatic logic hazard();
`ifdef RF_LOAD_USE_STALL_EN
        return ex_is_load && df_ex_enable && df_ex_reg != 5'd0 &&
               (df_ex_reg == rs1_addr || df_ex_reg == rs2_addr);
`else
        return 1'b0;
`endif
    endfunction

    // predict the outputs after the coming edge, push them, advance the model, wait a cycle
    task automatic step();
        exp_t e;
        logic h;
        h = hazard();
        if (reset || flush_in || (!stall_in && h)) begin
            e.d1 = '0; e.d2 = '0; e.a1 = '0; e.a2 = '0;
        end else if (stall_in) begin
            e = mout;
        end else begin
            e.d1 = operand(rs1_addr); e.d2 = operand(rs2_addr);
            e.a1 = rs1_addr;          e.a2 = rs2_addr;
        end
        e.so = h;
        mout = e;
        sb.push_back(e);
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
        end else if (wb_en && wb_reg != 5'd0) begin
            mregs[wb_reg] = wb_data;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; stall_in = 0; flush_in = 0; wb_en = 0; ex_is_load = 0;
        df_ex_enable = 0; df_mem_enable = 0; df_wb_enable = 0;
        wb_reg = 0; df_ex_reg = 0; df_mem_reg = 0; df_wb_reg = 0;
        wb_data = 0; df_ex_data = 0; df_mem_data = 0; df_wb_data = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    endtask

    // monitor: outputs are presented every cycle, compare one scoreboard entry per edge
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rs1_data_out", rs1_data_out, e.d1);
            chk("rs2_data_out", rs2_data_out, e.d2);
            chk("rs1_addr_out", {27'd0, rs1_addr_out}, {27'd0, e.a1});
            chk("rs2_addr_out", {27'd0, rs2_addr_out}, {27'd0, e.a2});
            chk("stall_out", {31'd0, stall_out}, {31'd0, e.so});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        idle();
        reset = 1; wb_en = 1; wb_reg = 3; wb_data = 32'hBAD0BAD0; rs1_addr = 3; rs2_addr = 9;
        step(); step();
        idle();
        for (int i = 1; i < 32; i++) begin
            rs1_addr = i[4:0]; rs2_addr = 5'(32 - i);
            step();
        end
        wb_en = 1; wb_reg = 5; wb_data = 32'hDEADBEEF; rs1_addr = 0;
        step();
        wb_en = 0; rs1_addr = 5;
        step();
        wb_en = 1; wb_reg = 7; wb_data = 32'h44; rs1_addr = 0;
        step();
        wb_en = 0; rs1_addr = 7; rs2_addr = 7;
        df_ex_enable = 1;  df_ex_reg = 7;  df_ex_data = 32'h11;
        df_mem_enable = 1; df_mem_reg = 7; df_mem_data = 32'h22;
        df_wb_enable = 1;  df_wb_reg = 7;  df_wb_data = 32'h33;
        step();
        df_ex_enable = 0;  step();
        df_mem_enable = 0; step();
        df_wb_enable = 0;  step();
        wb_en = 1; wb_reg = 0; wb_data = 32'hFFFFFFFF;
        df_ex_enable = 1; df_ex_reg = 0; df_ex_data = 32'hAAAA5555; rs1_addr = 0; rs2_addr = 0;
        step();
        idle(); rs1_addr = 0; rs2_addr = 5;
        step();
        df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'h12345678; rs1_addr = 9; rs2_addr = 9;
        step();
        df_ex_enable = 0; stall_in = 1; wb_en = 1; wb_reg = 12;
        for (int i = 0; i < 3; i++) begin
            rs1_addr = 5'($urandom_range(0, 31)); rs2_addr = 5'($urandom_range(0, 31));
            wb_data = 32'hCAFE0000 + i;
            step();
        end
        wb_en = 0; flush_in = 1;
        step();
        idle(); rs1_addr = 12; rs2_addr = 5;
        step();
        ex_is_load = 1; df_ex_enable = 1; df_ex_reg = 3; df_ex_data = 32'h5A5A5A5A;
        rs1_addr = 0; rs2_addr = 3;
        step();
        rs2_addr = 4;
        step();
        idle();
        for (int n = 0; n < 400; n++) begin
            reset         = $urandom_range(0, 99) == 0;
            stall_in      = $urandom_range(0, 7) == 0;
            flush_in      = $urandom_range(0, 15) == 0;
            ex_is_load    = $urandom_range(0, 3) == 0;
            rs1_addr      = 5'($urandom_range(0, 7));
            rs2_addr      = 5'($urandom_range(0, 7));
            wb_en         = 1'($urandom_range(0, 1));
            wb_reg        = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            df_ex_enable  = 1'($urandom_range(0, 1));
            df_ex_reg     = 5'($urandom_range(0, 7));
            df_ex_data    = $urandom;
            df_mem_enable = 1'($urandom_range(0, 1));
            df_mem_reg    = 5'($urandom_range(0, 7));
            df_mem_data   = $urandom;
            df_wb_enable  = 1'($urandom_range(0, 1));
            df_wb_reg     = 5'($urandom_range(0, 7));
            df_wb_data    = $urandom;
            step();
        end
        idle();
        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
